// File: rtl/iter_shifter.sv
// iter_shifter: multi-cycle 16-bit shifter built around a single 2-bit shift stage.
// A start in IDLE captures the operand, op and amount. SHIFT then applies one step per
// clock: a 2-bit step while at least two positions remain, otherwise a 1-bit step.
// DONE shows the result for one cycle.
//
// Ports:
//   clk     - system clock; all state updates on the rising edge
//   rst_n   - synchronous active-low reset
//   start   - operation request; only sampled in IDLE
//   op      - 0 rotate left, 1 shift left logical, 2 shift right arith, 3 shift right logical
//   dataIn  - operand, captured when start is accepted
//   amt     - shift amount 0..15, captured when start is accepted
//   busy    - high whenever the FSM is not in IDLE
//   done    - one-cycle pulse; result is valid
//   result  - shifted value; held from done until the next accepted start
module iter_shifter #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] dataIn,
    input  logic [AMT_W-1:0] amt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_ROL = 2'd0;
    localparam logic [1:0] OP_SLL = 2'd1;
    localparam logic [1:0] OP_SRA = 2'd2;
    localparam logic [1:0] OP_SRL = 2'd3;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q,  work_d;
    logic [1:0]       op_q,    op_d;
    logic [AMT_W-1:0] cnt_q,   cnt_d;

    logic             stage_en;
    logic             stage_two;
    logic [WIDTH-1:0] stage_out;

    // Shift stage: moves by 2 positions when stage_two is set, else by 1; passes through when disabled.
    always_comb begin
        stage_out = work_q;
        if (stage_en) begin
            unique case (op_q)
                OP_ROL: stage_out = stage_two ? {work_q[WIDTH-3:0], work_q[WIDTH-1:WIDTH-2]}
                                              : {work_q[WIDTH-2:0], work_q[WIDTH-1]};
                OP_SLL: stage_out = stage_two ? {work_q[WIDTH-3:0], 2'b00}
                                              : {work_q[WIDTH-2:0], 1'b0};
                OP_SRA: stage_out = stage_two ? {{2{work_q[WIDTH-1]}}, work_q[WIDTH-1:2]}
                                              : {work_q[WIDTH-1], work_q[WIDTH-1:1]};
                OP_SRL: stage_out = stage_two ? {2'b00, work_q[WIDTH-1:2]}
                                              : {1'b0, work_q[WIDTH-1:1]};
                default: stage_out = work_q;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            work_q  <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: capture in IDLE, one stage step per SHIFT cycle, single DONE cycle.
    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        stage_en  = 1'b0;
        stage_two = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    work_d  = dataIn;
                    op_d    = op;
                    cnt_d   = amt;
                    state_d = (amt == AMT_W'(0)) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                stage_en  = 1'b1;
                stage_two = (cnt_q >= AMT_W'(2));
                work_d    = stage_out;
                cnt_d     = stage_two ? (cnt_q - AMT_W'(2)) : AMT_W'(0);
                if (cnt_d == AMT_W'(0)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode directly from registered state; the work register doubles as the result.
    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign result = work_q;

endmodule

// File: tb/tb_iter_shifter.sv
// Directed bench for iter_shifter with a result scoreboard drained on each done pulse.
module tb_iter_shifter;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [15:0] dataIn;
    logic [3:0]  amt;
    logic        busy;
    logic        done;
    logic [15:0] result;

    int unsigned total;
    int unsigned bad;
    logic [15:0] exp_q[$];

    iter_shifter #(.WIDTH(16), .AMT_W(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .dataIn (dataIn),
        .amt    (amt),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference shift on the full amount in one go.
    function automatic logic [15:0] model(input logic [1:0] o, input logic [15:0] d, input logic [3:0] a);
        logic [31:0]        w;
        logic signed [15:0] s;
        w = {16'h0000, d};
        s = d;
        case (o)
            2'd0:    model = 16'((w << a) | (w >> (16 - int'(a))));
            2'd1:    model = 16'(w << a);
            2'd2:    model = 16'(s >>> a);
            default: model = 16'(w >> a);
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        total++;
        assert (got === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, expv);
        end
    endtask

    // Scoreboard drain: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'(0));
            end else begin
                check("result_on_done", 32'(result), 32'(exp_q.pop_front()));
            end
        end
    end

    // Present a request for one cycle; returns after the accepting edge.
    task automatic issue(input logic [1:0] o, input logic [15:0] d, input logic [3:0] a, input bit push);
        @(negedge clk);
        start  = 1'b1;
        op     = o;
        dataIn = d;
        amt    = a;
        if (push) exp_q.push_back(model(o, d, a));
        @(negedge clk);
        start  = 1'b0;
        op     = $urandom_range(0, 3);
        dataIn = 16'($urandom);
        amt    = 4'($urandom);
    endtask

    // Count busy cycles from the current negedge; bounded.
    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy && cyc < 40) begin
            cyc++;
            @(negedge clk);
        end
        if (busy) check("busy_timeout", 32'(busy), 32'(0));
    endtask

    task automatic run(input string tag, input logic [1:0] o, input logic [15:0] d, input logic [3:0] a);
        int cyc;
        issue(o, d, a, 1'b1);
        wait_idle(cyc);
        check({tag, "_busy_cycles"}, 32'(cyc), 32'((int'(a) + 1) / 2 + 1));
        check({tag, "_held"}, 32'(result), 32'(model(o, d, a)));
    endtask

    initial begin
        int cyc;
        rst_n  = 1'b0;
        start  = 1'b0;
        op     = 2'd0;
        dataIn = 16'h0000;
        amt    = 4'd0;
        total  = 0;
        bad    = 0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'(0));
        check("reset_done", 32'(done), 32'(0));
        check("reset_result", 32'(result), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Rotate with odd amount: 2-bit then 1-bit step.
        run("rol3", 2'd0, 16'h8001, 4'd3);
        check("rol3_const", 32'(result), 32'h000C);
        // Worst-case amount, arithmetic then logical right.
        run("sra15", 2'd2, 16'h8000, 4'd15);
        check("sra15_const", 32'(result), 32'hFFFF);
        run("srl15", 2'd3, 16'h8000, 4'd15);
        check("srl15_const", 32'(result), 32'h0001);
        // Zero amount goes straight to DONE.
        run("sll0", 2'd1, 16'h00FF, 4'd0);
        check("sll0_const", 32'(result), 32'h00FF);

        // Start during SHIFT must be ignored.
        issue(2'd1, 16'h00FF, 4'd4, 1'b1);
        start  = 1'b1;
        op     = 2'd1;
        dataIn = 16'h1234;
        amt    = 4'd1;
        @(negedge clk);
        start = 1'b0;
        wait_idle(cyc);
        check("busy_start_result", 32'(result), 32'h0FF0);
        repeat (3) @(negedge clk);
        check("busy_start_no_restart", 32'(busy), 32'(0));

        // Reset in the middle of an operation abandons it.
        run("srl8", 2'd3, 16'hF0F0, 4'd8);
        check("srl8_const", 32'(result), 32'h00F0);
        issue(2'd0, 16'hABCD, 4'd10, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_busy", 32'(busy), 32'(0));
        check("midrst_done", 32'(done), 32'(0));
        check("midrst_result", 32'(result), 32'(0));
        repeat (8) @(negedge clk);
        check("midrst_idle", 32'(busy), 32'(0));
        run("after_rst", 2'd1, 16'h0003, 4'd5);

        // Back-to-back: start during the done cycle is ignored, then accepted in IDLE.
        issue(2'd0, 16'h1234, 4'd4, 1'b1);
        cyc = 0;
        while (!done && cyc < 40) begin
            cyc++;
            @(negedge clk);
        end
        check("b2b_done_seen", 32'(done), 32'(1));
        start  = 1'b1;
        op     = 2'd0;
        dataIn = 16'h1234;
        amt    = 4'd12;
        @(negedge clk);
        check("b2b_done_start_ignored", 32'(busy), 32'(0));
        check("b2b_first_result", 32'(result), 32'h2341);
        exp_q.push_back(16'h4123);
        @(negedge clk);
        start = 1'b0;
        check("b2b_second_busy", 32'(busy), 32'(1));
        wait_idle(cyc);
        check("b2b_second_result", 32'(result), 32'h4123);

        // A few random operations.
        for (int i = 0; i < 8; i++) begin
            run("rand", 2'($urandom_range(0, 3)), 16'($urandom), 4'($urandom));
        end

        repeat (2) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
